seq6_monitor: RTL and testbench

SEQ6_MONITOR -- requirements
Module: seq6_monitor

---
 rtl/seq6_monitor.sv | 135 +++++++++++++
 tb/tb_seq6_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq6_monitor.sv
// rtl/seq6_monitor.sv - tracks a 6-state JK counter sequence, counts cycles, flags faults
// Outputs are registered and reflect the cnt_in sampled at the same edge.
module seq6_monitor (
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] cnt_in,
  input  logic       err_clr,
  output logic [2:0] pos,
  output logic       pos_valid,
  output logic       wrap_pulse,
  output logic [7:0] cycles,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_prev;
  logic [2:0] r_pos;
  logic       r_pos_valid;
  logic       r_wrap_pulse;
  logic [7:0] r_cycles;
  logic       r_err;
  logic [1:0] r_err_code;

  logic       w_legal;
  logic [2:0] w_idx;
  logic [2:0] w_succ;
  logic       w_wrap;

  always_comb begin
    w_legal = 1'b1;
    w_idx   = 3'd0;
    case (cnt_in)
      3'b000:  w_idx = 3'd0;
      3'b010:  w_idx = 3'd1;
      3'b011:  w_idx = 3'd2;
      3'b110:  w_idx = 3'd3;
      3'b101:  w_idx = 3'd4;
      3'b001:  w_idx = 3'd5;
      default: w_legal = 1'b0;
    endcase
  end

  // prev is always a legal code while LOCKED, so the default arm only covers 001->000
  always_comb begin
    case (r_prev)
      3'b000:  w_succ = 3'b010;
      3'b010:  w_succ = 3'b011;
      3'b011:  w_succ = 3'b110;
      3'b110:  w_succ = 3'b101;
      3'b101:  w_succ = 3'b001;
      default: w_succ = 3'b000;
    endcase
  end

  assign w_wrap = (r_prev == 3'b001) && (cnt_in == 3'b000);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state      <= ST_ACQUIRE;
      r_prev       <= 3'b000;
      r_pos        <= 3'd0;
      r_pos_valid  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_cycles     <= 8'd0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      r_prev       <= cnt_in;
      r_wrap_pulse <= 1'b0;
      case (r_state)
        ST_ACQUIRE: begin
          if (!w_legal) begin
            r_state     <= ST_FAULT;
            r_err       <= 1'b1;
            r_err_code  <= 2'b10;
            r_pos_valid <= 1'b0;
          end else if (cnt_in == 3'b000) begin
            r_state     <= ST_LOCKED;
            r_pos       <= 3'd0;
            r_pos_valid <= 1'b1;
          end else begin
            r_pos_valid <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (!w_legal) begin
            r_state     <= ST_FAULT;
            r_err       <= 1'b1;
            r_err_code  <= 2'b10;
            r_pos_valid <= 1'b0;
          end else if (cnt_in == w_succ) begin
            r_pos       <= w_idx;
            r_pos_valid <= 1'b1;
            if (w_wrap) begin
              r_wrap_pulse <= 1'b1;
              if (r_cycles != 8'hff) r_cycles <= r_cycles + 8'd1;
            end
          end else begin
            r_state     <= ST_FAULT;
            r_err       <= 1'b1;
            r_err_code  <= 2'b01;
            r_pos_valid <= 1'b0;
          end
        end
        ST_FAULT: begin
          r_pos_valid <= 1'b0;
          if (err_clr) begin
            r_state    <= ST_ACQUIRE;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
          end
        end
        default: begin
          r_state     <= ST_ACQUIRE;
          r_pos_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pos        = r_pos;
  assign pos_valid  = r_pos_valid;
  assign wrap_pulse = r_wrap_pulse;
  assign cycles     = r_cycles;
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_seq6_monitor.sv
// tb/tb_seq6_monitor.sv - directed and randomized checks of seq6_monitor against a reference model
module tb_seq6_monitor;

  logic       clk;
  logic       clear;
  logic [2:0] cnt_in;
  logic       err_clr;
  logic [2:0] pos;
  logic       pos_valid;
  logic       wrap_pulse;
  logic [7:0] cycles;
  logic       err;
  logic [1:0] err_code;

  seq6_monitor dut (
    .clk        (clk),
    .clear      (clear),
    .cnt_in     (cnt_in),
    .err_clr    (err_clr),
    .pos        (pos),
    .pos_valid  (pos_valid),
    .wrap_pulse (wrap_pulse),
    .cycles     (cycles),
    .err        (err),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] seq [6] = '{3'b000, 3'b010, 3'b011, 3'b110, 3'b101, 3'b001};

  // reference model state
  bit         m_locked, m_fault;
  logic [2:0] m_prev;
  int         m_pos, m_cycles, m_code;
  bit         m_valid, m_wrap, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [2:0] c);
    for (int i = 0; i < 6; i++) if (seq[i] == c) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_fault = 0; m_prev = 3'b000;
    m_pos = 0; m_cycles = 0; m_code = 0;
    m_valid = 0; m_wrap = 0; m_err = 0;
  endfunction

  function automatic void model_edge(input logic [2:0] c, input logic e);
    int ci, pi;
    ci = idx_of(c);
    pi = idx_of(m_prev);
    m_wrap = 0;
    if (m_fault) begin
      if (e) begin m_fault = 0; m_err = 0; m_code = 0; end
    end else if (ci < 0) begin
      m_fault = 1; m_locked = 0; m_err = 1; m_code = 2; m_valid = 0;
    end else if (!m_locked) begin
      if (ci == 0) begin m_locked = 1; m_pos = 0; m_valid = 1; end
    end else if (pi >= 0 && ci == (pi + 1) % 6) begin
      m_pos = ci;
      if (ci == 0) begin
        m_wrap = 1;
        if (m_cycles < 255) m_cycles++;
      end
    end else begin
      m_fault = 1; m_locked = 0; m_err = 1; m_code = 1; m_valid = 0;
    end
    m_prev = c;
  endfunction

  task automatic check_all();
    chk("pos",        pos,        m_pos);
    chk("pos_valid",  pos_valid,  m_valid);
    chk("wrap_pulse", wrap_pulse, m_wrap);
    chk("cycles",     cycles,     m_cycles);
    chk("err",        err,        m_err);
    chk("err_code",   err_code,   m_code);
  endtask

  // called from a negedge: drive, clock once, sample on the following negedge
  task automatic step(input logic [2:0] c, input logic e);
    cnt_in  = c;
    err_clr = e;
    @(posedge clk);
    model_edge(c, e);
    @(negedge clk);
    check_all();
  endtask

  // clear pulled between edges; outputs must drop without a clock edge
  task automatic mid_reset();
    #2 clear = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    clear = 1'b1;
  endtask

  task automatic run_cycle();
    for (int i = 1; i < 6; i++) step(seq[i], 1'b0);
    step(seq[0], 1'b0);
  endtask

  initial begin
    clear = 1'b0; cnt_in = 3'b000; err_clr = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    clear = 1'b1;

    // full legal cycle from reset
    step(3'b000, 1'b0);
    chk("lock_pos_valid", pos_valid, 1);
    run_cycle();
    chk("cycle_wrap", wrap_pulse, 1);
    chk("cycle_count", cycles, 1);

    // release mid-stream at 011
    mid_reset();
    step(3'b011, 1'b0);
    step(3'b110, 1'b0);
    step(3'b101, 1'b0);
    step(3'b001, 1'b0);
    chk("acq_valid_low", pos_valid, 0);
    step(3'b000, 1'b0);
    chk("acq_lock_nowrap", wrap_pulse, 0);
    chk("acq_lock_cycles", cycles, 0);

    // skip a code -> bad transition, later illegal code ignored
    step(3'b010, 1'b0);
    step(3'b110, 1'b0);
    chk("skip_code", err_code, 1);
    chk("skip_pos_held", pos, 1);
    step(3'b111, 1'b0);
    chk("first_fault_kept", err_code, 1);

    // illegal code, clear, relock with cycles retained
    step(3'b010, 1'b1);
    step(3'b000, 1'b0);
    run_cycle();
    step(3'b010, 1'b0);
    step(3'b111, 1'b0);
    chk("illegal_code", err_code, 2);
    step(3'b011, 1'b1);
    chk("err_cleared", err, 0);
    step(3'b110, 1'b0);
    step(3'b000, 1'b0);
    chk("relock_cycles", cycles, 1);

    // saturation
    for (int k = 0; k < 260; k++) run_cycle();
    chk("saturated", cycles, 255);
    chk("sat_wrap", wrap_pulse, 1);

    // async clear while locked with cycles=7
    mid_reset();
    step(3'b000, 1'b0);
    for (int k = 0; k < 7; k++) run_cycle();
    chk("pre_clear_cycles", cycles, 7);
    step(3'b010, 1'b0);
    mid_reset();

    // randomized stream with occasional glitches, err_clr and resets
    begin
      int ph;
      logic [2:0] c;
      ph = $urandom_range(0, 5);
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 15) == 0) c = 3'($urandom_range(0, 7));
        else c = seq[ph];
        ph = (ph + 1) % 6;
        step(c, ($urandom_range(0, 7) == 0));
        if ($urandom_range(0, 399) == 0) mid_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
